// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional build macro: MEM_ARB_RR_EN (round-robin tie-break instead of fixed data priority).
package cpu_mem_pkg;

    localparam int AW_DEFAULT       = 32;
    localparam int DW_DEFAULT       = 32;
    localparam int MAX_WAIT_DEFAULT = 15;

    // Arbiter FSM: one idle state plus one busy state per owner
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// MEM_ARB_RR_EN defined: tie goes to the requester not granted last, and the
// next value of the last-grant flag is produced here. Undefined: data always wins.
module mem_arb_pick (
    input  logic en_i,        // arbiter is free to grant this cycle
    input  logic if_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_q_i,    // 1 = data owned the previous grant
    output logic last_d_o,
`endif
    output logic gnt_if_o,
    output logic gnt_d_o
);

    // Pick a winner only when a grant can actually be issued
    always_comb begin
        gnt_if_o = 1'b0;
        gnt_d_o  = 1'b0;
        if (en_i) begin
`ifdef MEM_ARB_RR_EN
            if (if_req_i && d_req_i) begin
                gnt_d_o  = !last_q_i;
                gnt_if_o = last_q_i;
            end else begin
                gnt_d_o  = d_req_i;
                gnt_if_o = if_req_i;
            end
`else
            gnt_d_o  = d_req_i;
            gnt_if_o = if_req_i && !d_req_i;
`endif
        end
    end

`ifdef MEM_ARB_RR_EN
    // Flag follows whoever actually won; unchanged when nothing is granted
    assign last_d_o = (gnt_d_o || gnt_if_o) ? gnt_d_o : last_q_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch (read-only) and a data
// (read/write) requester. One transaction at a time, with a wait-cycle
// timeout that reports arb_err and completes the owner with rdata=0.
// Optional build macro: MEM_ARB_RR_EN (round-robin tie-break).
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // shared memory
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          arb_err
);

    // Timeout fires on the edge that closes the MAX_WAIT-th busy cycle
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_e    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_gnt_q, if_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          arb_err_q, arb_err_d;

    logic          busy;
    logic          gap;
    logic          grant_ok;
    logic          pick_if, pick_d;
    logic          done_ok, done_to;

    assign busy     = (state_q != ST_IDLE);
    // The rvalid cycle is a forced idle cycle, so a new grant lands two
    // cycles after a completion at the earliest.
    assign gap      = if_rvalid_q || d_rvalid_q;
    assign grant_ok = (state_q == ST_IDLE) && !gap;
    assign done_ok  = busy && mem_ready;
    assign done_to  = busy && !mem_ready && (cnt_q == WAIT_LAST);

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Last-grant flag for the round-robin tie-break
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b0;
        else        last_q <= last_d;
    end
`endif

    mem_arb_pick u_pick (
        .en_i     (grant_ok),
        .if_req_i (if_req),
        .d_req_i  (d_req),
`ifdef MEM_ARB_RR_EN
        .last_q_i (last_q),
        .last_d_o (last_d),
`endif
        .gnt_if_o (pick_if),
        .gnt_d_o  (pick_d)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: grant from idle, return to idle on completion or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_d)       state_d = ST_BUSY_D;
                else if (pick_if) state_d = ST_BUSY_IF;
            end
            ST_BUSY_IF,
            ST_BUSY_D: begin
                if (done_ok || done_to) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values: latch request on grant, return data on completion
    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        arb_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    d_gnt_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                end else if (pick_if) begin
                    if_gnt_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                end
            end
            ST_BUSY_IF,
            ST_BUSY_D: begin
                cnt_d = cnt_q + 8'd1;
                if (done_ok) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == ST_BUSY_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        d_rvalid_d = 1'b1;
                        // writes complete without touching the read data
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                    end
                end else if (done_to) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    arb_err_d = 1'b1;
                    if (state_q == ST_BUSY_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = '0;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            arb_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            arb_err_q   <= arb_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign arb_err   = arb_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default parameters, MAX_WAIT=15).
// Honours MEM_ARB_RR_EN for the back-to-back grant order check.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, arb_err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .arb_err   (arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int   got;
        int   exp_w;

        rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;

        // reset state
        repeat (3) step();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_gnt_rv", {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 0);
        chk("rst_arb_err", 32'(arb_err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // single fetch, ready on 2nd busy cycle
        if_req = 1; if_addr = 32'h10;
        step();
        chk("f_if_gnt", 32'(if_gnt), 1);
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_d_gnt", 32'(d_gnt), 0);
        if_req = 0;
        step();
        chk("f_gnt_pulse", 32'(if_gnt), 0);
        chk("f_req_hold", 32'(mem_req), 1);
        mem_ready = 1; mem_rdata = 32'h00A00093;
        step();
        chk("f_rvalid", 32'(if_rvalid), 1);
        chk("f_rdata", if_rdata, 32'h00A00093);
        chk("f_req_drop", 32'(mem_req), 0);
        mem_ready = 0;
        step();
        chk("f_rvalid_pulse", 32'(if_rvalid), 0);

        // simultaneous requests: data first, fetch two cycles after d_rvalid
        if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        chk("s_d_gnt", 32'(d_gnt), 1);
        chk("s_if_gnt0", 32'(if_gnt), 0);
        chk("s_mem_addr", mem_addr, 32'h100);
        d_req = 0; mem_ready = 1; mem_rdata = 32'h12345678;
        step();
        chk("s_d_rvalid", 32'(d_rvalid), 1);
        chk("s_d_rdata", d_rdata, 32'h12345678);
        mem_ready = 0;
        step();
        chk("s_gap", 32'(if_gnt), 0);
        step();
        chk("s_if_gnt", 32'(if_gnt), 1);
        chk("s_if_addr", mem_addr, 32'h10);
        if_req = 0; mem_ready = 1; mem_rdata = 32'h55;
        step();
        chk("s_if_rdata", if_rdata, 32'h55);
        // mem_ready in idle must not complete anything
        step();
        step();
        chk("idle_ready", {30'd0, if_rvalid, d_rvalid}, 0);
        chk("idle_mem_req", 32'(mem_req), 0);
        mem_ready = 0;

        // write that never completes: timeout after 15 busy cycles
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        step();
        chk("t_d_gnt", 32'(d_gnt), 1);
        chk("t_mem_we", 32'(mem_we), 1);
        chk("t_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t_mem_addr", mem_addr, 32'h200);
        d_req = 0;
        ok = 1'b1;
        repeat (14) begin
            step();
            if (!mem_req || arb_err || mem_addr != 32'h200 || d_rvalid) ok = 1'b0;
        end
        chk("t_busy_stable", 32'(ok), 1);
        step();
        chk("t_arb_err", 32'(arb_err), 1);
        chk("t_d_rvalid", 32'(d_rvalid), 1);
        chk("t_mem_req", 32'(mem_req), 0);
        chk("t_d_rdata", d_rdata, 0);
        step();
        chk("t_err_pulse", 32'(arb_err), 0);

        // ready on exactly the 15th busy cycle wins over timeout
        d_req = 1; d_we = 0; d_addr = 32'h300;
        step();
        d_req = 0;
        repeat (14) step();
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        step();
        chk("e_d_rvalid", 32'(d_rvalid), 1);
        chk("e_arb_err", 32'(arb_err), 0);
        chk("e_d_rdata", d_rdata, 32'hCAFEF00D);
        mem_ready = 0;
        step();

        // write completion leaves d_rdata alone
        d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'h1;
        step();
        d_req = 0; mem_ready = 1; mem_rdata = 32'hBAD;
        step();
        chk("w_d_rvalid", 32'(d_rvalid), 1);
        chk("w_d_rdata", d_rdata, 32'hCAFEF00D);
        mem_ready = 0;
        step();

        // reset during fetch busy, data request pending
        d_we = 0;
        if_req = 1; if_addr = 32'h40;
        step();
        chk("r_if_gnt", 32'(if_gnt), 1);
        if_req = 0; d_req = 1; d_addr = 32'h500;
        step();
        #2 rst_n = 1'b0;
        #1 chk("r_mem_req_async", 32'(mem_req), 0);
        step();
        chk("r_no_rvalid", 32'(if_rvalid), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("r_d_gnt", 32'(d_gnt), 1);
        chk("r_d_addr", mem_addr, 32'h500);
        chk("r_if_rvalid", 32'(if_rvalid), 0);
        d_req = 0; mem_ready = 1; mem_rdata = 32'h77;
        step();
        chk("r_d_rdata", d_rdata, 32'h77);
        mem_ready = 0;

        // both requesters held high for 4 transactions, fresh after reset
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk) rst_n = 1'b1;
        if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h600; if_addr = 32'h20;
        for (int t = 0; t < 4; t++) begin
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                step();
                if (d_gnt) got = 1;
                else if (if_gnt) got = 2;
            end
`ifdef MEM_ARB_RR_EN
            exp_w = (t % 2 == 0) ? 1 : 2;
`else
            exp_w = 1;
`endif
            chk($sformatf("order_%0d", t), 32'(got), 32'(exp_w));
            mem_ready = 1;
            step();
            mem_ready = 0;
        end
        if_req = 0; d_req = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, memory address width.
REQ-002 SHALL have parameter DW, default 32, memory data width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, maximum BUSY cycles before timeout (range 1..255).
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req in 1, if_addr in AW, forming the fetch read request.
REQ-007 SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out DW, forming the fetch accept and return.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in AW, d_wdata in DW, forming the data read or write request.
REQ-009 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out DW, forming the data accept and completion.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, forming the shared single-port memory request.
REQ-011 SHALL have ports mem_ready in 1, mem_rdata in DW, forming the memory completion.
REQ-012 SHALL have port arb_err  out  1, a one-cycle timeout pulse.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_IF and BUSY_D.
REQ-014 SHALL sample requests only in IDLE; a request must stay high until its gnt, and a request dropped before gnt is withdrawn without effect.
REQ-015 In IDLE with any request at edge N, SHALL enter the winner's BUSY state, latch its addr/we/wdata onto mem_*, assert mem_req, and pulse the winner's gnt for exactly one cycle (cycle N+1).
REQ-016 SHALL hold mem_req high and mem_addr, mem_we and mem_wdata stable throughout BUSY.
REQ-017 When mem_ready is sampled high in BUSY, SHALL drop mem_req, register mem_rdata into the owner's rdata, pulse the owner's rvalid for one cycle, and return to IDLE; d_rvalid also pulses for writes, with d_rdata unchanged.
REQ-018 SHALL insert at least one IDLE cycle between transactions, so a new grant occurs no sooner than 2 cycles after completion.
REQ-019 Without the configuration macro, data SHALL have fixed priority over fetch on simultaneous requests.
REQ-020 SHALL count BUSY cycles with an 8-bit counter, cleared on grant; if the count reaches MAX_WAIT without mem_ready, it SHALL drop mem_req, pulse arb_err and the owner's rvalid with rdata=0, and return to IDLE.
REQ-021 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win and arb_err SHALL stay low.
REQ-022 SHALL ignore mem_ready in IDLE.

Reset
REQ-023 On rst_n low, SHALL go to IDLE immediately and drive mem_req, mem_we, all gnt/rvalid outputs and arb_err to 0, mem_addr, mem_wdata and both rdata outputs to 0, and the wait counter and the last-grant flag to 0.
REQ-024 Reset mid-BUSY SHALL drop the transaction with no rvalid, and the first grant SHALL occur no earlier than one edge after rst_n rises.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: round-robin, where on a tie the requester not granted last wins; after reset, data wins the first tie.
REQ-026 Macro MEM_ARB_RR_EN undefined: fixed data priority, with no last-grant flag present.

Structure
REQ-027 Package cpu_mem_pkg SHALL hold the FSM state enum, the AW/DW defaults and the MAX_WAIT default.
REQ-028 Sub-module mem_arb_pick (combinational winner select, including the RR flag logic) SHALL be instantiated once; there SHALL be no other sub-modules.

Verification
REQ-029 Single fetch: if_req with if_addr=0x10, mem_ready after 2 BUSY cycles, mem_rdata=0x00A00093 -> if_gnt at N+1, mem_addr=0x10, if_rvalid with if_rdata=0x00A00093.
REQ-030 Simultaneous if_req and d_req (read 0x100) with fixed priority -> d_gnt first, if_gnt no earlier than 2 cycles after d_rvalid.
REQ-031 MEM_ARB_RR_EN with both requesters continuously asserting for 4 transactions -> grant order D, IF, D, IF.
REQ-032 Write d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ready never asserted, MAX_WAIT=15 -> arb_err and d_rvalid pulse on the 15th BUSY cycle and mem_req falls.
REQ-033 Reset asserted during BUSY_IF -> mem_req=0 immediately, no if_rvalid; after release, a pending d_req is granted normally.
REQ-034 mem_ready on exactly the MAX_WAIT-th cycle -> normal completion with arb_err=0.
